dsp_sum_accum2: RTL and testbench
=================================

Name: dsp_sum_accum2

Overview:
- Dual-channel integrate-and-dump stage directly downstream of the dual 24-bit DSP48E adder (25-bit unsigned sums OUT1/OUT2).
- Sums DUMP_LEN valid samples per channel and emits one widened result per channel with a single-cycle valid strobe.
- Feeds the decimated-output path.

Parameters:
- IN_W, 25, input sample width (unsigned), matches adder sum width.
- ACC_W, 32, accumulator/output width; must be >= IN_W.
- DUMP_LEN, 16, samples per dump; legal range 1..65535.
- CNT_W, 16, sample counter width; 2^CNT_W must be > DUMP_LEN-1.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- CLR  in  1  synchronous abort: discard partial frame.
- IN_VLD  in  1  IN1/IN2 valid this cycle.
- IN1  in  IN_W  channel-1 sum from adder.
- IN2  in  IN_W  channel-2 sum from adder.
- OUT1  out  ACC_W  channel-1 dumped total, registered, held between dumps.
- OUT2  out  ACC_W  channel-2 dumped total.
- OUT_VLD  out  1  one-cycle pulse: OUT1/OUT2 updated.
- BUSY  out  1  high while a partial frame is held (state ACCUM).
- OVF1, OVF2  out  1  per-dump overflow flags, valid with OUT_VLD (see Optional Feature).

Behaviour:
- Reset: state IDLE; ACC1, ACC2, OUT1, OUT2, CNT = 0; OUT_VLD, BUSY, OVF1, OVF2 = 0. Reset mid-frame discards the partial frame with no output.
- States: IDLE (no samples held) and ACCUM (1..DUMP_LEN-1 samples held).
- Arithmetic: zero-extend IN to ACC_W. next = ACC + IN for both channels, in parallel, in the same cycle.
- IN_VLD sample when CNT < DUMP_LEN-1:
  - ACC <= next; CNT <= CNT+1; state ACCUM.
- IN_VLD sample when CNT == DUMP_LEN-1 (last sample):
  - OUT <= next; OUT_VLD = 1 next cycle; ACC <= 0; CNT <= 0; state IDLE.
  - No dead cycle: the following IN_VLD starts a fresh frame.
- Latency: OUT_VLD rises exactly 1 cycle after the CLK edge that samples the last IN_VLD.
- Throughput: one sample per cycle; gaps in IN_VLD are allowed and only pause counting.
- DUMP_LEN = 1: every valid sample is dumped directly; OUT = zero-extended IN after 1 cycle; state never leaves IDLE.
- CLR priority: CLR beats IN_VLD in the same cycle; that sample is dropped. CLR zeroes ACC and CNT, goes to IDLE, and leaves OUT1/OUT2 untouched.
- OUT_VLD is never asserted by CLR.
- OUT_VLD is high for one cycle only; OUT1/OUT2 are stable until the next dump.
- BUSY = (state == ACCUM), registered.

Optional Feature:
- Macro: DSP_SUM_ACCUM2_SAT_EN.
- Defined:
  - Each channel's add detects carry-out of ACC_W. On carry, the accumulator clamps to all-ones and stays clamped for the rest of the frame.
  - The channel's sticky overflow bit is set. At dump it is copied to OVF1/OVF2, then cleared; CLR and RST also clear it.
- Undefined:
  - Modulo-2^ACC_W wrap.
  - OVF1/OVF2 tied to 0.

Decomposition:
- Package dsp_accum_pkg: state encoding constants (ST_IDLE, ST_ACCUM), default widths IN_W/ACC_W, and the saturation all-ones constant function.
- One sub-module is natural: dsp_accum_lane, a single-channel add/saturate/hold datapath instantiated twice.
- Counter and FSM are shared in the top level.

Test Plan:
- DUMP_LEN=4, IN1=10, IN2=1115, four back-to-back IN_VLD -> OUT_VLD one cycle after the 4th sample; OUT1=40, OUT2=4460; OUT_VLD low the next cycle.
- DUMP_LEN=4, IN_VLD with 3-cycle gaps, IN1=2020 -> OUT1=8080; only one OUT_VLD pulse; BUSY high from first sample to dump.
- CLR asserted together with the 3rd IN_VLD, then 4 valid samples of 8 -> the first partial frame is discarded; OUT1=32; the earlier OUT value is held until then.
- ACC_W=26, DUMP_LEN=4, IN1=25'h1FFFFFF x4 -> with macro OUT1=26'h3FFFFFF and OVF1=1; without macro OUT1=26'h3FFFFFC and OVF1=0.
- RST pulsed after 2 of 4 samples, then 4 samples of 5 -> no output from the aborted frame; OUT1=20.
- DUMP_LEN=1, IN1=8299999 -> OUT1=8299999 one cycle later, with an OUT_VLD pulse on every valid.

Source files
------------

// File: rtl/dsp_accum_pkg.sv
// Shared types and constants for the dual-channel integrate-and-dump stage.
// Holds the controller state encoding, default widths and the saturation constant helper.
// Imported by the lane datapath and the top level.
package dsp_accum_pkg;

    localparam int IN_W_DEF  = 25;
    localparam int ACC_W_DEF = 32;
    localparam int SAT_MAX_W = 64;

    // IDLE: no samples held; ACCUM: a partial frame is held
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // All-ones pattern of the low w bits, used as the saturation clamp value
    function automatic logic [SAT_MAX_W-1:0] sat_ones(input int unsigned w);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_sum_accum2_if.sv
// Bus bundle between the adder/decimator path and the integrate-and-dump stage.
// No latency of its own; carries sample strobe, abort, dumped totals and status.
// No backpressure: the producer may present a sample every cycle.
interface dsp_sum_accum2_if #(
    parameter int IN_W  = 25,
    parameter int ACC_W = 32
);
    logic             CLR;
    logic             IN_VLD;
    logic [IN_W-1:0]  IN1;
    logic [IN_W-1:0]  IN2;
    logic [ACC_W-1:0] OUT1;
    logic [ACC_W-1:0] OUT2;
    logic             OUT_VLD;
    logic             BUSY;
    logic             OVF1;
    logic             OVF2;

    modport master (
        output CLR, IN_VLD, IN1, IN2,
        input  OUT1, OUT2, OUT_VLD, BUSY, OVF1, OVF2
    );

    modport slave (
        input  CLR, IN_VLD, IN1, IN2,
        output OUT1, OUT2, OUT_VLD, BUSY, OVF1, OVF2
    );
endinterface

// File: rtl/dsp_accum_lane.sv
// Single-channel accumulate / optional saturate / hold-result datapath (macro DSP_SUM_ACCUM2_SAT_EN).
// Result register updates on the edge that samples the frame's last sample.
// No backpressure: accepts one sample per cycle whenever smp_vld is high.
module dsp_accum_lane
    import dsp_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             smp_vld,
    input  logic             smp_last,
    input  logic [IN_W-1:0]  smp_dat,
    output logic [ACC_W-1:0] out_dat,
    output logic             ovf
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic [ACC_W-1:0] next_acc;

`ifdef DSP_SUM_ACCUM2_SAT_EN
    localparam logic [ACC_W-1:0] ACC_ONES = ACC_W'(sat_ones(ACC_W));

    logic             sticky_q, sticky_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_w;
    logic             sat_now;

    // Widened add exposes carry-out; once a frame has overflowed it stays clamped
    always_comb begin
        sum_w    = {1'b0, acc_q} + (ACC_W+1)'(smp_dat);
        sat_now  = sum_w[ACC_W] | sticky_q;
        next_acc = sat_now ? ACC_ONES : sum_w[ACC_W-1:0];
    end

    // Accumulator, held result and overflow tracking for one frame
    always_comb begin
        acc_d    = acc_q;
        out_d    = out_q;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        if (clr) begin
            acc_d    = '0;
            sticky_d = 1'b0;
        end else if (smp_vld) begin
            if (smp_last) begin
                out_d    = next_acc;
                ovf_d    = sat_now;
                acc_d    = '0;
                sticky_d = 1'b0;
            end else begin
                acc_d    = next_acc;
                sticky_d = sat_now;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            out_q    <= '0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            out_q    <= out_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Plain modulo-2^ACC_W add of the zero-extended sample
    always_comb begin
        next_acc = acc_q + ACC_W'(smp_dat);
    end

    // Accumulator and held result for one frame
    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (clr) begin
            acc_d = '0;
        end else if (smp_vld) begin
            if (smp_last) begin
                out_d = next_acc;
                acc_d = '0;
            end else begin
                acc_d = next_acc;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign ovf = 1'b0;
`endif

    assign out_dat = out_q;

endmodule

// File: rtl/dsp_sum_accum2.sv
// Dual-channel integrate-and-dump of DUMP_LEN valid samples (saturation via DSP_SUM_ACCUM2_SAT_EN).
// OUT_VLD is a one-cycle pulse registered on the edge that samples the last sample.
// No backpressure: one sample per cycle, IN_VLD gaps only pause counting.
module dsp_sum_accum2
    import dsp_accum_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int DUMP_LEN = 16,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    dsp_sum_accum2_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_vld_q, out_vld_d;
    logic             last_smp;

    assign last_smp = (cnt_q == LAST_CNT);

    // Shared sample counter and frame FSM; CLR wins over a same-cycle sample
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_vld_d = 1'b0;
        if (bus.CLR) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (bus.IN_VLD) begin
            if (last_smp) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                out_vld_d = 1'b1;
            end else begin
                state_d = ST_ACCUM;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // Controller registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    dsp_accum_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane1 (
        .clk      (CLK),
        .rst      (RST),
        .clr      (bus.CLR),
        .smp_vld  (bus.IN_VLD),
        .smp_last (last_smp),
        .smp_dat  (bus.IN1),
        .out_dat  (bus.OUT1),
        .ovf      (bus.OVF1)
    );

    dsp_accum_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane2 (
        .clk      (CLK),
        .rst      (RST),
        .clr      (bus.CLR),
        .smp_vld  (bus.IN_VLD),
        .smp_last (last_smp),
        .smp_dat  (bus.IN2),
        .out_dat  (bus.OUT2),
        .ovf      (bus.OVF2)
    );

    assign bus.OUT_VLD = out_vld_q;
    assign bus.BUSY    = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_dsp_sum_accum2.sv
// Directed bench for dsp_sum_accum2: three instances cover DUMP_LEN=4, ACC_W=26 overflow and DUMP_LEN=1.
// Inputs change 1 time unit after the rising edge; outputs are observed at the same point.
// Expected values are hand-computed constants.
module tb_dsp_sum_accum2;

    logic CLK;
    logic RST;
    int   pass_cnt;
    int   total_cnt;

    dsp_sum_accum2_if #(.IN_W(25), .ACC_W(32)) bus_a ();
    dsp_sum_accum2_if #(.IN_W(25), .ACC_W(26)) bus_b ();
    dsp_sum_accum2_if #(.IN_W(25), .ACC_W(32)) bus_c ();

    dsp_sum_accum2 #(.IN_W(25), .ACC_W(32), .DUMP_LEN(4), .CNT_W(16)) dut_a (
        .CLK (CLK), .RST (RST), .bus (bus_a)
    );
    dsp_sum_accum2 #(.IN_W(25), .ACC_W(26), .DUMP_LEN(4), .CNT_W(16)) dut_b (
        .CLK (CLK), .RST (RST), .bus (bus_b)
    );
    dsp_sum_accum2 #(.IN_W(25), .ACC_W(32), .DUMP_LEN(1), .CNT_W(16)) dut_c (
        .CLK (CLK), .RST (RST), .bus (bus_c)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        bus_a.CLR = 0; bus_a.IN_VLD = 0; bus_a.IN1 = '0; bus_a.IN2 = '0;
        bus_b.CLR = 0; bus_b.IN_VLD = 0; bus_b.IN1 = '0; bus_b.IN2 = '0;
        bus_c.CLR = 0; bus_c.IN_VLD = 0; bus_c.IN1 = '0; bus_c.IN2 = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_all();
        tick(); tick(); tick();
        RST = 1'b0;
        total_cnt++; if (bus_a.OUT1 !== 32'd0) $display("FAIL reset_out1: got %0d want 0", bus_a.OUT1); else pass_cnt++;
        total_cnt++; if (bus_a.OUT2 !== 32'd0) $display("FAIL reset_out2: got %0d want 0", bus_a.OUT2); else pass_cnt++;
        total_cnt++; if (bus_a.OUT_VLD !== 1'b0) $display("FAIL reset_out_vld: got %0b want 0", bus_a.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_a.BUSY !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus_a.BUSY); else pass_cnt++;
        total_cnt++; if ({bus_a.OVF1, bus_a.OVF2} !== 2'b00) $display("FAIL reset_ovf: got %0b want 00", {bus_a.OVF1, bus_a.OVF2}); else pass_cnt++;
        total_cnt++; if (bus_b.OUT1 !== 26'd0) $display("FAIL reset_b_out1: got %0h want 0", bus_b.OUT1); else pass_cnt++;
        total_cnt++; if (bus_c.OUT1 !== 32'd0) $display("FAIL reset_c_out1: got %0d want 0", bus_c.OUT1); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            bus_a.IN_VLD = 1; bus_a.IN1 = 25'd10; bus_a.IN2 = 25'd1115;
            tick();
            if (i < 3) begin
                total_cnt++; if (bus_a.OUT_VLD !== 1'b0) $display("FAIL b2b_early_vld[%0d]: got %0b want 0", i, bus_a.OUT_VLD); else pass_cnt++;
                total_cnt++; if (bus_a.BUSY !== 1'b1) $display("FAIL b2b_busy[%0d]: got %0b want 1", i, bus_a.BUSY); else pass_cnt++;
            end
        end
        bus_a.IN_VLD = 0;
        total_cnt++; if (bus_a.OUT_VLD !== 1'b1) $display("FAIL b2b_out_vld: got %0b want 1", bus_a.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_a.OUT1 !== 32'd40) $display("FAIL b2b_out1: got %0d want 40", bus_a.OUT1); else pass_cnt++;
        total_cnt++; if (bus_a.OUT2 !== 32'd4460) $display("FAIL b2b_out2: got %0d want 4460", bus_a.OUT2); else pass_cnt++;
        total_cnt++; if (bus_a.BUSY !== 1'b0) $display("FAIL b2b_busy_end: got %0b want 0", bus_a.BUSY); else pass_cnt++;
        tick();
        total_cnt++; if (bus_a.OUT_VLD !== 1'b0) $display("FAIL b2b_vld_drop: got %0b want 0", bus_a.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_a.OUT1 !== 32'd40) $display("FAIL b2b_hold: got %0d want 40", bus_a.OUT1); else pass_cnt++;
    endtask

    task automatic test_gaps();
        int pulses;
        pulses = 0;
        for (int s = 0; s < 4; s++) begin
            bus_a.IN_VLD = 1; bus_a.IN1 = 25'd2020; bus_a.IN2 = 25'd3;
            tick();
            bus_a.IN_VLD = 0;
            if (bus_a.OUT_VLD === 1'b1) pulses++;
            if (s < 3) begin
                total_cnt++; if (bus_a.BUSY !== 1'b1) $display("FAIL gap_busy_smp[%0d]: got %0b want 1", s, bus_a.BUSY); else pass_cnt++;
                for (int g = 0; g < 3; g++) begin
                    tick();
                    if (bus_a.OUT_VLD === 1'b1) pulses++;
                    total_cnt++; if (bus_a.BUSY !== 1'b1) $display("FAIL gap_busy_gap[%0d.%0d]: got %0b want 1", s, g, bus_a.BUSY); else pass_cnt++;
                end
            end else begin
                total_cnt++; if (bus_a.BUSY !== 1'b0) $display("FAIL gap_busy_end: got %0b want 0", bus_a.BUSY); else pass_cnt++;
                total_cnt++; if (bus_a.OUT1 !== 32'd8080) $display("FAIL gap_out1: got %0d want 8080", bus_a.OUT1); else pass_cnt++;
                total_cnt++; if (bus_a.OUT2 !== 32'd12) $display("FAIL gap_out2: got %0d want 12", bus_a.OUT2); else pass_cnt++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus_a.OUT_VLD === 1'b1) pulses++;
        end
        total_cnt++; if (pulses !== 1) $display("FAIL gap_pulse_count: got %0d want 1", pulses); else pass_cnt++;
    endtask

    task automatic test_clr();
        bus_a.IN_VLD = 1; bus_a.IN1 = 25'd100; bus_a.IN2 = 25'd100;
        tick(); tick();
        bus_a.CLR = 1;
        tick();
        bus_a.CLR = 0; bus_a.IN_VLD = 0;
        total_cnt++; if (bus_a.OUT_VLD !== 1'b0) $display("FAIL clr_no_vld: got %0b want 0", bus_a.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_a.BUSY !== 1'b0) $display("FAIL clr_busy: got %0b want 0", bus_a.BUSY); else pass_cnt++;
        total_cnt++; if (bus_a.OUT1 !== 32'd8080) $display("FAIL clr_hold_out1: got %0d want 8080", bus_a.OUT1); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus_a.IN_VLD = 1; bus_a.IN1 = 25'd8; bus_a.IN2 = 25'd1;
            tick();
            if (i == 2) begin
                total_cnt++; if (bus_a.OUT1 !== 32'd8080) $display("FAIL clr_hold_pre: got %0d want 8080", bus_a.OUT1); else pass_cnt++;
                total_cnt++; if (bus_a.OUT_VLD !== 1'b0) $display("FAIL clr_early_vld: got %0b want 0", bus_a.OUT_VLD); else pass_cnt++;
            end
        end
        bus_a.IN_VLD = 0;
        total_cnt++; if (bus_a.OUT_VLD !== 1'b1) $display("FAIL clr_out_vld: got %0b want 1", bus_a.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_a.OUT1 !== 32'd32) $display("FAIL clr_out1: got %0d want 32", bus_a.OUT1); else pass_cnt++;
        total_cnt++; if (bus_a.OUT2 !== 32'd4) $display("FAIL clr_out2: got %0d want 4", bus_a.OUT2); else pass_cnt++;
        tick();
    endtask

    task automatic test_rst_midframe();
        bus_a.IN_VLD = 1; bus_a.IN1 = 25'd7; bus_a.IN2 = 25'd7;
        tick(); tick();
        bus_a.IN_VLD = 0;
        RST = 1;
        tick();
        RST = 0;
        total_cnt++; if (bus_a.OUT_VLD !== 1'b0) $display("FAIL rst_no_vld: got %0b want 0", bus_a.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_a.BUSY !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus_a.BUSY); else pass_cnt++;
        total_cnt++; if (bus_a.OUT1 !== 32'd0) $display("FAIL rst_out1_zero: got %0d want 0", bus_a.OUT1); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus_a.IN_VLD = 1; bus_a.IN1 = 25'd5; bus_a.IN2 = 25'd6;
            tick();
            if (i == 1) begin
                total_cnt++; if (bus_a.OUT_VLD !== 1'b0) $display("FAIL rst_stale_vld: got %0b want 0", bus_a.OUT_VLD); else pass_cnt++;
            end
        end
        bus_a.IN_VLD = 0;
        total_cnt++; if (bus_a.OUT_VLD !== 1'b1) $display("FAIL rst_out_vld: got %0b want 1", bus_a.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_a.OUT1 !== 32'd20) $display("FAIL rst_out1: got %0d want 20", bus_a.OUT1); else pass_cnt++;
        total_cnt++; if (bus_a.OUT2 !== 32'd24) $display("FAIL rst_out2: got %0d want 24", bus_a.OUT2); else pass_cnt++;
        tick();
    endtask

    task automatic test_overflow();
        logic [25:0] exp_out1;
        logic        exp_ovf1;
`ifdef DSP_SUM_ACCUM2_SAT_EN
        exp_out1 = 26'h3FFFFFF;
        exp_ovf1 = 1'b1;
`else
        exp_out1 = 26'h3FFFFFC;
        exp_ovf1 = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            bus_b.IN_VLD = 1; bus_b.IN1 = 25'h1FFFFFF; bus_b.IN2 = 25'd1;
            tick();
        end
        bus_b.IN_VLD = 0;
        total_cnt++; if (bus_b.OUT_VLD !== 1'b1) $display("FAIL ovf_out_vld: got %0b want 1", bus_b.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_b.OUT1 !== exp_out1) $display("FAIL ovf_out1: got %0h want %0h", bus_b.OUT1, exp_out1); else pass_cnt++;
        total_cnt++; if (bus_b.OVF1 !== exp_ovf1) $display("FAIL ovf_flag1: got %0b want %0b", bus_b.OVF1, exp_ovf1); else pass_cnt++;
        total_cnt++; if (bus_b.OUT2 !== 26'd4) $display("FAIL ovf_out2: got %0h want 4", bus_b.OUT2); else pass_cnt++;
        total_cnt++; if (bus_b.OVF2 !== 1'b0) $display("FAIL ovf_flag2: got %0b want 0", bus_b.OVF2); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus_b.IN_VLD = 1; bus_b.IN1 = 25'd3; bus_b.IN2 = 25'd1;
            tick();
        end
        bus_b.IN_VLD = 0;
        total_cnt++; if (bus_b.OUT1 !== 26'd12) $display("FAIL ovf_next_frame_out1: got %0h want c", bus_b.OUT1); else pass_cnt++;
        total_cnt++; if (bus_b.OVF1 !== 1'b0) $display("FAIL ovf_next_frame_flag1: got %0b want 0", bus_b.OVF1); else pass_cnt++;
        tick();
    endtask

    task automatic test_dump_len1();
        bus_c.IN_VLD = 1; bus_c.IN1 = 25'd8299999; bus_c.IN2 = 25'd1;
        tick();
        total_cnt++; if (bus_c.OUT_VLD !== 1'b1) $display("FAIL dl1_vld0: got %0b want 1", bus_c.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_c.OUT1 !== 32'd8299999) $display("FAIL dl1_out1_0: got %0d want 8299999", bus_c.OUT1); else pass_cnt++;
        total_cnt++; if (bus_c.BUSY !== 1'b0) $display("FAIL dl1_busy: got %0b want 0", bus_c.BUSY); else pass_cnt++;
        bus_c.IN1 = 25'd12345; bus_c.IN2 = 25'd2;
        tick();
        bus_c.IN_VLD = 0;
        total_cnt++; if (bus_c.OUT_VLD !== 1'b1) $display("FAIL dl1_vld1: got %0b want 1", bus_c.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_c.OUT1 !== 32'd12345) $display("FAIL dl1_out1_1: got %0d want 12345", bus_c.OUT1); else pass_cnt++;
        total_cnt++; if (bus_c.OUT2 !== 32'd2) $display("FAIL dl1_out2_1: got %0d want 2", bus_c.OUT2); else pass_cnt++;
        tick();
        total_cnt++; if (bus_c.OUT_VLD !== 1'b0) $display("FAIL dl1_vld_idle: got %0b want 0", bus_c.OUT_VLD); else pass_cnt++;
        total_cnt++; if (bus_c.OUT1 !== 32'd12345) $display("FAIL dl1_hold: got %0d want 12345", bus_c.OUT1); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        RST       = 1'b1;
        idle_all();
        test_reset();
        test_back_to_back();
        test_gaps();
        test_clr();
        test_rst_midframe();
        test_overflow();
        test_dump_len1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
